// File: rtl/rpll_sim_dyn.sv
// Cycle-based rPLL model: CLKOUT is synthesised from the fast CLKIN with a
// phase accumulator, plus lock timing, restart, phase-delayed and divided outputs.
module rpll_sim_dyn #(
   parameter string FCLKIN       = "27",
   parameter int    IDIV_SEL     = 8,
   parameter int    FBDIV_SEL    = 3,
   parameter int    ODIV_SEL     = 48,
   parameter string DYN_SEL      = "false",
   parameter int    DYN_SDIV_SEL = 2,
   parameter int    LOCK_CYCLES  = 64
) (
   input  logic       CLKIN_i,
   input  logic       RESET_i,
   input  logic       RESET_P_i,
   input  logic       CLKFB_i,
   input  logic [5:0] FBDSEL_i,
   input  logic [5:0] IDSEL_i,
   input  logic [5:0] ODSEL_i,
   input  logic [3:0] PSDA_i,
   input  logic [3:0] DUTYDA_i,
   input  logic [3:0] FDLY_i,
   output logic       CLKOUT_o,
   output logic       CLKOUTP_o,
   output logic       CLKOUTD_o,
   output logic       CLKOUTD3_o,
   output logic       LOCK_o
);

   localparam bit             DYN       = (DYN_SEL == "true");
   localparam int             LCW       = $clog2(LOCK_CYCLES + 1);
   localparam int             SDW       = $clog2(DYN_SDIV_SEL);
   localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_CYCLES);
   localparam logic [SDW-1:0] SDIV_LAST = SDW'(DYN_SDIV_SEL - 1);
   localparam logic [6:0]     N_STATIC  = 7'(FBDIV_SEL + 1);
   localparam logic [6:0]     D_STATIC  = 7'(IDIV_SEL + 1);

   // Dynamic selects count down from 64, so a select of 0 means a ratio of 64.
   function automatic logic [6:0] sel_to_ratio(input logic [5:0] sel);
      return 7'd64 - {1'b0, sel};
   endfunction

   // Returns {toggle, next_acc}; N >= D clamps to a toggle on every edge.
   function automatic logic [7:0] acc_step(input logic [6:0] acc,
                                           input logic [6:0] n,
                                           input logic [6:0] d);
      logic [7:0] sum;
      sum = {1'b0, acc} + {1'b0, n};
      if (n >= d)
         return {1'b1, 7'd0};
      else if (sum >= {1'b0, d})
         return {1'b1, 7'(sum - {1'b0, d})};
      else
         return {1'b0, sum[6:0]};
   endfunction

   logic [11:0]    sel_q, sel_d;
   logic           sel_vld_q, sel_vld_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           lock_q, lock_d;
   logic [6:0]     acc_q, acc_d;
   logic           clk_q, clk_d;
   logic [15:0]    dl_q, dl_d;
   logic           clkp_q, clkp_d;
   logic [SDW-1:0] divd_cnt_q, divd_cnt_d;
   logic           clkd_q, clkd_d;
   logic [1:0]     div3_cnt_q, div3_cnt_d;
   logic           clkd3_q, clkd3_d;

   logic       tog;
   logic       sel_chg;
   logic       restart;
   logic [6:0] ratio_n;
   logic [6:0] ratio_d;
   logic       unused_ign;

   // The registered select is only compared once it has captured a real value.
   assign sel_chg = DYN && sel_vld_q && ({FBDSEL_i, IDSEL_i} != sel_q);
   assign restart = RESET_P_i || sel_chg;
   assign ratio_n = DYN ? sel_to_ratio(sel_q[11:6]) : N_STATIC;
   assign ratio_d = DYN ? sel_to_ratio(sel_q[5:0])  : D_STATIC;

   assign unused_ign = (^{CLKFB_i, ODSEL_i, DUTYDA_i, FDLY_i}) ^ (FCLKIN == "27") ^ (ODIV_SEL == 48);

   always_comb begin
      sel_d      = {FBDSEL_i, IDSEL_i};
      sel_vld_d  = 1'b1;
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);
      lock_d     = (lock_cnt_d == LOCK_MAX);
      {tog, acc_d} = lock_q ? acc_step(acc_q, ratio_n, ratio_d) : 8'd0;
      clk_d      = clk_q ^ tog;
      dl_d       = {dl_q[14:0], clk_d};
      clkp_d     = (PSDA_i == 4'd0) ? clk_d : dl_q[PSDA_i - 4'd1];
      divd_cnt_d = divd_cnt_q;
      clkd_d     = clkd_q;
      div3_cnt_d = div3_cnt_q;
      clkd3_d    = clkd3_q;
      if (tog) begin
         if (divd_cnt_q == SDIV_LAST) begin
            divd_cnt_d = '0;
            clkd_d     = ~clkd_q;
         end else begin
            divd_cnt_d = divd_cnt_q + SDW'(1);
         end
         if (div3_cnt_q == 2'd2) begin
            div3_cnt_d = 2'd0;
            clkd3_d    = ~clkd3_q;
         end else begin
            div3_cnt_d = div3_cnt_q + 2'd1;
         end
      end
      // A restart looks exactly like RESET except that the select is still captured.
      if (restart) begin
         lock_cnt_d = '0;
         lock_d     = 1'b0;
         acc_d      = '0;
         clk_d      = 1'b0;
         dl_d       = '0;
         clkp_d     = 1'b0;
         divd_cnt_d = '0;
         clkd_d     = 1'b0;
         div3_cnt_d = '0;
         clkd3_d    = 1'b0;
      end
   end

   always_ff @(posedge CLKIN_i or posedge RESET_i) begin
      if (RESET_i) begin
         sel_q      <= '0;
         sel_vld_q  <= 1'b0;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
         acc_q      <= '0;
         clk_q      <= 1'b0;
         dl_q       <= '0;
         clkp_q     <= 1'b0;
         divd_cnt_q <= '0;
         clkd_q     <= 1'b0;
         div3_cnt_q <= '0;
         clkd3_q    <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         sel_vld_q  <= sel_vld_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
         acc_q      <= acc_d;
         clk_q      <= clk_d;
         dl_q       <= dl_d;
         clkp_q     <= clkp_d;
         divd_cnt_q <= divd_cnt_d;
         clkd_q     <= clkd_d;
         div3_cnt_q <= div3_cnt_d;
         clkd3_q    <= clkd3_d;
      end
   end

   assign CLKOUT_o   = clk_q;
   assign CLKOUTP_o  = clkp_q;
   assign CLKOUTD_o  = clkd_q;
   assign CLKOUTD3_o = clkd3_q;
   assign LOCK_o     = lock_q;

endmodule

// File: tb/tb_rpll_sim_dyn.sv
// Bench for rpll_sim_dyn: three configurations (default, clamped, dynamic) checked
// every cycle against a toggle-count model, plus hand-computed edge expectations.
module tb_rpll_sim_dyn;

   localparam int LC = 64;
   localparam int NI = 3;
   localparam int HL = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rst_p, clkfb;
   logic [5:0]    fbdsel, idsel, odsel;
   logic [3:0]    psda, dutyda, fdly;
   logic [NI-1:0] co, cp, cd, cd3, lk;

   rpll_sim_dyn u_def (
      .CLKIN_i(clk), .RESET_i(rst), .RESET_P_i(rst_p), .CLKFB_i(clkfb),
      .FBDSEL_i(fbdsel), .IDSEL_i(idsel), .ODSEL_i(odsel), .PSDA_i(psda),
      .DUTYDA_i(dutyda), .FDLY_i(fdly),
      .CLKOUT_o(co[0]), .CLKOUTP_o(cp[0]), .CLKOUTD_o(cd[0]), .CLKOUTD3_o(cd3[0]), .LOCK_o(lk[0])
   );

   rpll_sim_dyn #(.FBDIV_SEL(9), .IDIV_SEL(4), .DYN_SDIV_SEL(128)) u_clamp (
      .CLKIN_i(clk), .RESET_i(rst), .RESET_P_i(rst_p), .CLKFB_i(clkfb),
      .FBDSEL_i(fbdsel), .IDSEL_i(idsel), .ODSEL_i(odsel), .PSDA_i(psda),
      .DUTYDA_i(dutyda), .FDLY_i(fdly),
      .CLKOUT_o(co[1]), .CLKOUTP_o(cp[1]), .CLKOUTD_o(cd[1]), .CLKOUTD3_o(cd3[1]), .LOCK_o(lk[1])
   );

   rpll_sim_dyn #(.DYN_SEL("true"), .DYN_SDIV_SEL(4)) u_dyn (
      .CLKIN_i(clk), .RESET_i(rst), .RESET_P_i(rst_p), .CLKFB_i(clkfb),
      .FBDSEL_i(fbdsel), .IDSEL_i(idsel), .ODSEL_i(odsel), .PSDA_i(psda),
      .DUTYDA_i(dutyda), .FDLY_i(fdly),
      .CLKOUT_o(co[2]), .CLKOUTP_o(cp[2]), .CLKOUTD_o(cd[2]), .CLKOUTD3_o(cd3[2]), .LOCK_o(lk[2])
   );

   int          checks = 0;
   int          errors = 0;
   int          t = -1;
   bit          armed = 1'b0;
   int          pn [NI];
   int          pd [NI];
   int          ps [NI];
   bit          pdyn [NI];
   int          e [NI];
   int          lastr [NI];
   bit          logc [NI][HL];
   logic [11:0] selp;
   bit          svld;
   bit          x_co [NI];
   bit          x_cp [NI];
   bit          x_cd [NI];
   bit          x_cd3 [NI];
   bit          x_lk [NI];
   int          hp = 0;
   int          hr = 0;

   // Model: e = edges since restart; after lock, k advancing edges give
   // floor(k*N/D) CLKOUT toggles (k when N >= D); dividers follow the toggle count.
   task automatic model_edge();
      bit dynr;
      int n, d, k, tg, back;
      t++;
      dynr = !rst && svld && ({fbdsel, idsel} != selp);
      if (rst) svld = 1'b0;
      else begin
         selp = {fbdsel, idsel};
         svld = 1'b1;
      end
      for (int i = 0; i < NI; i++) begin
         if (rst || rst_p || (pdyn[i] && dynr)) begin
            e[i]     = 0;
            lastr[i] = t;
         end else begin
            e[i]++;
         end
         n  = pdyn[i] ? 64 - int'(selp[11:6]) : pn[i];
         d  = pdyn[i] ? 64 - int'(selp[5:0])  : pd[i];
         k  = (e[i] > LC) ? e[i] - LC : 0;
         tg = (n >= d) ? k : (k * n) / d;
         x_lk[i]  = (e[i] >= LC);
         x_co[i]  = tg[0];
         x_cd[i]  = ((tg / ps[i]) % 2) == 1;
         x_cd3[i] = ((tg / 3) % 2) == 1;
         logc[i][t] = x_co[i];
         back = t - int'(psda);
         if (back >= lastr[i]) x_cp[i] = logc[i][back];
         else                  x_cp[i] = 1'b0;
      end
      armed = 1'b1;
   endtask

   task automatic chk(input string nm, input int i, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] t=%0d got %b want %b", nm, i, t, act, exp);
      end
   endtask

   task automatic zeros(input string nm);
      for (int i = 0; i < NI; i++) begin
         chk({nm, "_CLKOUT"},   i, co[i],  1'b0);
         chk({nm, "_CLKOUTP"},  i, cp[i],  1'b0);
         chk({nm, "_CLKOUTD"},  i, cd[i],  1'b0);
         chk({nm, "_CLKOUTD3"}, i, cd3[i], 1'b0);
         chk({nm, "_LOCK"},     i, lk[i],  1'b0);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_ignored();
      clkfb  = 1'($urandom);
      odsel  = 6'($urandom);
      dutyda = 4'($urandom);
      fdly   = 4'($urandom);
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   initial forever begin
      @(negedge clk);
      if (armed) begin
         for (int i = 0; i < NI; i++) begin
            chk("CLKOUT",   i, co[i],  x_co[i]);
            chk("CLKOUTP",  i, cp[i],  x_cp[i]);
            chk("CLKOUTD",  i, cd[i],  x_cd[i]);
            chk("CLKOUTD3", i, cd3[i], x_cd3[i]);
            chk("LOCK",     i, lk[i],  x_lk[i]);
         end
      end
   end

   initial begin
      pn = '{4, 10, 4};
      pd = '{9, 5, 9};
      ps = '{2, 128, 4};
      pdyn = '{1'b0, 1'b0, 1'b1};
      rst = 1'b1; rst_p = 1'b0; clkfb = 1'b0;
      fbdsel = 6'd60; idsel = 6'd55; odsel = '0;
      psda = '0; dutyda = '0; fdly = '0;
      repeat (3) tick();
      zeros("rst_state");
      rst = 1'b0;

      // Release: lock timing, first toggles, PSDA window 70..80, PSDA=0 at 81.
      for (int n = 1; n <= 160; n++) begin
         tick();
         if (n == 63) chk("lock_e63", 0, lk[0], 1'b0);
         if (n == 64) begin
            chk("lock_e64", 0, lk[0], 1'b1);
            chk("lock_e64", 2, lk[2], 1'b1);
         end
         if (n == 65) chk("clamp_e65", 1, co[1], 1'b1);
         if (n == 66) begin
            chk("co_e66", 0, co[0], 1'b0);
            chk("clamp_e66", 1, co[1], 1'b0);
         end
         if (n == 67) begin
            chk("co_e67", 0, co[0], 1'b1);
            chk("co_e67", 2, co[2], 1'b1);
            chk("clamp_e67", 1, co[1], 1'b1);
         end
         if (n == 68) chk("cd_e68", 0, cd[0], 1'b0);
         if (n == 69) begin
            chk("co_e69", 0, co[0], 1'b0);
            chk("cd_e69", 0, cd[0], 1'b1);
         end
         if (n == 70) chk("cd3_e70", 0, cd3[0], 1'b0);
         if (n == 71) chk("cd3_e71", 0, cd3[0], 1'b1);
         if (n == 72) chk("cp5_e72", 0, cp[0], 1'b1);
         if (n == 74) chk("cp5_e74", 0, cp[0], 1'b0);
         if (n == 75) chk("co_e75", 0, co[0], 1'b0);
         if (n == 76) begin
            chk("co_e76", 0, co[0], 1'b1);
            chk("cp5_e76", 0, cp[0], 1'b1);
         end
         if (n == 80) chk("cp5_e80", 0, cp[0], 1'b0);
         if (n == 81) begin
            chk("cp0_e81", 0, cp[0], 1'b1);
            chk("lock_psda", 0, lk[0], 1'b1);
         end
         drive_ignored();
         if (n >= 69 && n <= 79) psda = 4'd5;
         else if (n == 80)       psda = 4'd0;
         else                    psda = 4'($urandom);
      end

      // Dynamic ratio change 60 -> 62: relock, then N=2, D=9.
      fbdsel = 6'd62;
      tick();
      chk("dyn_drop_lock", 2, lk[2], 1'b0);
      chk("dyn_drop_co",   2, co[2], 1'b0);
      chk("dyn_drop_cp",   2, cp[2], 1'b0);
      chk("dyn_drop_cd",   2, cd[2], 1'b0);
      chk("dyn_drop_cd3",  2, cd3[2], 1'b0);
      chk("static_hold",   0, lk[0], 1'b1);
      repeat (63) tick();
      chk("dyn_relock63", 2, lk[2], 1'b0);
      tick();
      chk("dyn_relock64", 2, lk[2], 1'b1);
      repeat (4) tick();
      chk("dyn_n2_e4", 2, co[2], 1'b0);
      tick();
      chk("dyn_n2_e5", 2, co[2], 1'b1);

      // RESET_P pulse of 5 cycles.
      rst_p = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         zeros("rstp_pulse");
      end
      rst_p = 1'b0;
      repeat (63) tick();
      chk("rstp_relock63", 0, lk[0], 1'b0);
      tick();
      chk("rstp_relock64", 0, lk[0], 1'b1);

      // Randomised operation.
      for (int c = 0; c < 2500; c++) begin
         tick();
         drive_ignored();
         psda  = 4'($urandom);
         rst_p = 1'b0;
         rst   = 1'b0;
         if (hp > 0) begin
            rst_p = 1'b1;
            hp--;
         end else if ($urandom_range(399, 0) == 0) begin
            rst_p = 1'b1;
            hp = $urandom_range(4, 0);
         end
         if (hr > 0) begin
            rst = 1'b1;
            hr--;
         end else if ($urandom_range(599, 0) == 0) begin
            rst = 1'b1;
            hr = $urandom_range(2, 0);
         end
         if ($urandom_range(249, 0) == 0) begin
            fbdsel = 6'($urandom_range(63, 48));
            idsel  = 6'($urandom_range(63, 40));
         end
         if (rst) begin
            #1;
            zeros("async_rst_rand");
         end
      end

      // Final asynchronous reset while everything is running.
      rst = 1'b0;
      rst_p = 1'b0;
      repeat (150) tick();
      chk("pre_rst_lock", 1, lk[1], 1'b1);
      rst = 1'b1;
      #1;
      zeros("async_rst");
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpll_sim_dyn.md
Name: rpll_sim_dyn

Overview:
Cycle-based simulation and FPGA-emulation model of the vendor rPLL primitive, and the successor to the pass-through model.
- Treats CLKIN as a fast master clock and derives CLKOUT with rational ratio (FBDIV+1)/(2*(IDIV+1)) of CLKIN using a phase accumulator.
- Models lock acquisition, relock on dynamic ratio change, RESET_P power-down, PSDA phase shift, and the CLKOUTD and CLKOUTD3 dividers.
- Drop-in for rPLL in simulation top-levels; all outputs are registered.

Parameters:
FCLKIN, "27", informational only, no effect.
IDIV_SEL, 8, static input divider; D = IDIV_SEL+1, range 0..63.
FBDIV_SEL, 3, static feedback divider; N = FBDIV_SEL+1, range 0..63.
ODIV_SEL, 48, accepted, no effect.
DYN_SEL, "false", "true" selects the dynamic ratio: N = 64-FBDSEL, D = 64-IDSEL.
DYN_SDIV_SEL, 2, CLKOUTD divide ratio, range 2..128.
LOCK_CYCLES, 64, CLKIN cycles from start or restart to LOCK; must be at least 1.

Ports:
CLKIN  input  1  master clock; all logic on its rising edge.
RESET  input  1  asynchronous active-high reset.
RESET_P  input  1  synchronous power-down, active high.
CLKFB  input  1  ignored (internal feedback).
FBDSEL  input  6  dynamic feedback select, used when DYN_SEL="true".
IDSEL  input  6  dynamic input select, used when DYN_SEL="true".
ODSEL  input  6  ignored.
PSDA  input  4  phase delay of CLKOUTP, in CLKIN cycles (0..15).
DUTYDA  input  4  ignored.
FDLY  input  4  ignored.
CLKOUT  output  1  main output clock.
CLKOUTP  output  1  CLKOUT delayed by PSDA CLKIN cycles.
CLKOUTD  output  1  CLKOUT divided by DYN_SDIV_SEL.
CLKOUTD3  output  1  CLKOUT divided by 3.
LOCK  output  1  lock indicator.

Behaviour:
- RESET is asynchronous and active-high; CLKIN is the only clock.
- RESET=1: lock_cnt, acc, all divider counters and the 16-bit delay line go to 0. CLKOUT, CLKOUTP, CLKOUTD, CLKOUTD3 and LOCK are all 0.
- Restart event: RESET_P=1 on an edge, or (DYN_SEL="true" and {FBDSEL,IDSEL} differs from its registered copy). On a restart event, the next edge clears everything as RESET does. The registered copy then captures the new value.
- Lock:
  - lock_cnt increments each edge with no restart event and saturates at LOCK_CYCLES.
  - LOCK=1 is registered on the edge where lock_cnt reaches LOCK_CYCLES, i.e. the LOCK_CYCLES-th edge after restart or RESET release.
- Accumulator (7-bit acc, always acc < D):
  - Advances only on edges where LOCK is already 1; otherwise acc and CLKOUT are held at 0.
  - Per advancing edge, if acc+N >= D: acc <= acc+N-D and CLKOUT toggles. Otherwise acc <= acc+N.
  - Result: N toggles per D edges; f(CLKOUT) = fCLKIN*N/(2D).
  - If N >= D: CLKOUT toggles every advancing edge and acc stays 0 (clamp at fCLKIN/2).
- Default sequence (N=4, D=9): acc runs 4, 8, 3T, 7, 2T, 6, 1T, 5, 0T (T = toggle), period 9 edges.
- CLKOUTP: delay line shifts CLKOUT every edge; CLKOUTP = CLKOUT sampled PSDA edges earlier. PSDA=0 gives CLKOUTP = CLKOUT in the same cycle. A PSDA change takes effect immediately with no relock.
- CLKOUTD: counts CLKOUT toggles and toggles on every DYN_SDIV_SEL-th CLKOUT toggle. Period = DYN_SDIV_SEL CLKOUT periods, 50% duty.
- CLKOUTD3: toggles on every 3rd CLKOUT toggle. Period = 3 CLKOUT periods, 50% duty.
- Both dividers update on the same edge as the qualifying CLKOUT toggle.
- Ignored inputs (CLKFB, ODSEL, DUTYDA, FDLY) have no effect under any value. X on them must not propagate to any output.
- Reset or restart mid-operation: every output drops to 0 on that edge or asynchronously. No partial-period glitch follows; CLKOUT restarts from acc=0 after the next lock.

Test Plan:
- Defaults, RESET released at edge 0 -> LOCK=0 through edge 63, LOCK=1 at edge 64. CLKOUT rises at edge 67, then falls 2 edges later, then follows a 9-edge period with 4 toggles.
- Clamp: FBDIV_SEL=9, IDIV_SEL=4 -> after lock, CLKOUT toggles every edge and acc stays 0.
- DYN_SEL="true", locked, then FBDSEL changes 60->62 -> next edge LOCK=0 and all clocks 0. LOCK returns 64 edges later. New pattern has N=2, D=64-IDSEL.
- RESET_P pulse of 5 cycles while locked -> outputs 0 throughout the pulse. LOCK reasserts 64 edges after RESET_P falls.
- PSDA=5 -> CLKOUTP equals CLKOUT delayed by exactly 5 edges. Changing PSDA to 0 makes CLKOUTP equal CLKOUT on the next cycle and LOCK stays 1.
- DYN_SDIV_SEL=4 -> CLKOUTD period = 4 CLKOUT periods and CLKOUTD3 period = 3 CLKOUT periods, each 50% duty. Asserting RESET mid-period zeroes all outputs asynchronously.
